game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer. It owns the menu → level-load → play → clear/over flow.
- It drives the map_switch `select` and `flag_cover` inputs and the music select (`select == 0` plays the menu track).
- Inputs are the decoded keyboard `key_down` vector and per-player goal/death flags from the player logic.
- It also tracks the highest unlocked level and mirrors status on the LEDs.

Parameters:
- NUM_LEVELS, 5: number of playable levels (1..NUM_LEVELS); must be ≤ 7.
- LOAD_CYCLES, 16: cycles held in LOAD after the level_load pulse, before PLAY.
- BANNER_CYCLES, 100_000_000: CLEAR banner duration (1 s at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- key_down  in  10  decoded key levels.
  - Bits 0 W, 1 A, 2 S, 3 D, 4 UP, 5 LEFT, 6 DOWN, 7 RIGHT, 8 ENTER, 9 other.
- p1_goal  in  1  player 1 standing on exit (level).
- p2_goal  in  1  player 2 standing on exit (level).
- p1_dead  in  1  player 1 killed (level or pulse).
- p2_dead  in  1  player 2 killed (level or pulse).
- select  out  3  0 = menu, else current level.
- flag_cover  out  1  1 = show cover layer.
- level_load  out  1  one-cycle pulse: reset player positions for `select`.
- player_en  out  1  players may move.
- banner  out  2  0 none, 1 clear, 2 game over.
- led  out  16  status mirror.

Behaviour:
- Reset values (async, rst=0): state MENU, cursor=1, unlocked=1, level=1, timer=0, key history=0.
  - Outputs: select=0, flag_cover=1, level_load=0, player_en=0, banner=0, led shows the reset state.
- Key events: press = key_down & ~key_down_q, with key_down_q registered every cycle. Held keys produce one event only.
  - NEXT = D|RIGHT, PREV = A|LEFT, BACK = S|DOWN, GO = ENTER.
  - Same-cycle priority: GO > BACK > (NEXT/PREV). NEXT and PREV in the same cycle cancel.
- MENU: select=0, flag_cover=1.
  - NEXT: cursor+1, saturating at unlocked.
  - PREV: cursor−1, saturating at 1.
  - GO: level←cursor, go to LOAD.
- LOAD: level_load=1 on the first cycle only. Timer counts LOAD_CYCLES, then PLAY. select=level, flag_cover=0, player_en=0.
- PLAY: player_en=1, flag_cover=0.
  - (p1_dead|p2_dead) → OVER. Death wins over a same-cycle goal.
  - Else (p1_goal & p2_goal) → CLEAR. A single player at the goal does nothing.
- CLEAR: banner=1, flag_cover=1. On entry, unlocked←max(unlocked, min(level+1, NUM_LEVELS)).
  - Leaves when the timer reaches BANNER_CYCLES−1, or on GO (skips the banner).
  - If level<NUM_LEVELS: level←level+1, cursor←level+1, go to LOAD.
  - Else: cursor←1, go to MENU.
- OVER: banner=2, flag_cover=1, no timeout.
  - GO → LOAD with the same level.
  - BACK → MENU, cursor←level.
- Timer: width $clog2(max(LOAD_CYCLES, BANNER_CYCLES)). Cleared on every state change; never wraps (the state exits first).
- All outputs are registered; a state change is visible on the outputs on the cycle after the triggering input.
- led mapping:
  - led[NUM_LEVELS−1:0] = thermometer of unlocked.
  - led[10:8] = state code: MENU 0, LOAD 1, PLAY 2, CLEAR 3, OVER 4, PAUSE 5.
  - led[15:13] = cursor.
  - All other bits are 0.
- Reset mid-level returns to MENU immediately, including mid-pulse; level_load drops asynchronously.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- Defined:
  - GO in PLAY → PAUSE: player_en=0, flag_cover=1, banner=0, select=level.
  - In PAUSE, GO → PLAY without level_load, and BACK → MENU.
  - Goal/death inputs are ignored in PAUSE.
- Undefined: the PAUSE state does not exist, and GO in PLAY is ignored.

Decomposition:
- Package game_pkg: state encoding (3-bit codes above), key bit index constants (KEY_W…KEY_ENTER), banner codes.
- Sub-module key_edge: registers key_down and outputs press events (10 bits).
- The FSM, timer and unlock logic stay in game_flow_ctrl.

Test Plan:
- Release rst, press D three times with unlocked=1 → cursor stays 1. Press ENTER → level_load pulses once, select=1; 16 cycles later player_en=1.
- In PLAY L1, assert p1_goal only → stays PLAY. Add p2_goal → CLEAR, banner=1, unlocked=2, led[1:0]=2'b11. After BANNER_CYCLES (override 8 in the bench) → LOAD, select=2.
- In PLAY, assert p2_dead and both goals in the same cycle → OVER, banner=2, unlocked unchanged. Press ENTER → LOAD with select unchanged.
- In OVER, press S and ENTER in the same cycle → LOAD (GO wins). In OVER, press DOWN alone → MENU, select=0, cursor=level.
- Clear level NUM_LEVELS → MENU, cursor=1, unlocked=5. Hold ENTER for 1000 cycles → exactly one LOAD entry. Assert rst during LOAD → MENU, level_load=0 at once.
- With GAME_PAUSE_EN defined: in PLAY, ENTER → PAUSE, player_en=0, and p1_dead is ignored. Press ENTER → PLAY with no level_load pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game flow sequencer: state codes, key bit
// positions and banner codes.
// Optional feature macro: GAME_PAUSE_EN adds the PAUSE state.
package game_pkg;

    // State codes double as the value mirrored on led[10:8]
    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_CLEAR = 3'd3,
`ifdef GAME_PAUSE_EN
        ST_OVER  = 3'd4,
        ST_PAUSE = 3'd5
`else
        ST_OVER  = 3'd4
`endif
    } state_e;

    typedef enum logic [1:0] {
        BANNER_NONE  = 2'd0,
        BANNER_CLEAR = 2'd1,
        BANNER_OVER  = 2'd2
    } banner_e;

    localparam int unsigned KEY_W     = 0;
    localparam int unsigned KEY_A     = 1;
    localparam int unsigned KEY_S     = 2;
    localparam int unsigned KEY_D     = 3;
    localparam int unsigned KEY_UP    = 4;
    localparam int unsigned KEY_LEFT  = 5;
    localparam int unsigned KEY_DOWN  = 6;
    localparam int unsigned KEY_RIGHT = 7;
    localparam int unsigned KEY_ENTER = 8;
    localparam int unsigned KEY_OTHER = 9;
    localparam int unsigned KEY_BITS  = 10;

    // Thermometer code: bit i set when i < n (n = number of unlocked levels)
    function automatic logic [6:0] unlock_therm(input logic [2:0] n);
        logic [6:0] t;
        t = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            t[i] = (3'(i) < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Keyboard edge detector: one press event per key on its rising level.
module key_edge
    import game_pkg::*;
#(
    parameter int unsigned W = KEY_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_down,
    output logic [W-1:0] press
);

    logic [W-1:0] key_down_d;
    logic [W-1:0] key_down_q;

    // Next key history is simply the current key levels
    always_comb begin
        key_down_d = key_down;
        press      = key_down & ~key_down_q;
    end

    // Key history register, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) key_down_q <= '0;
        else      key_down_q <= key_down_d;
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: menu -> load -> play -> clear/over flow,
// level unlock tracking and LED status mirror. All outputs are registered.
// Optional feature macro: GAME_PAUSE_EN (GO in PLAY pauses the game).
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int unsigned NUM_LEVELS    = 5,
    parameter int unsigned LOAD_CYCLES   = 16,
    parameter int unsigned BANNER_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  key_down,
    input  logic        p1_goal,
    input  logic        p2_goal,
    input  logic        p1_dead,
    input  logic        p2_dead,
    output logic [2:0]  select,
    output logic        flag_cover,
    output logic        level_load,
    output logic        player_en,
    output logic [1:0]  banner,
    output logic [15:0] led
);

    localparam int unsigned TMAX = (LOAD_CYCLES > BANNER_CYCLES) ? LOAD_CYCLES : BANNER_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] LOAD_LAST   = TW'(LOAD_CYCLES - 1);
    localparam logic [TW-1:0] BANNER_LAST = TW'(BANNER_CYCLES - 1);
    localparam logic [2:0]    LVL_MAX     = 3'(NUM_LEVELS);

    logic [9:0] press;
    logic       go, back, nxt, prv;
    logic       unused_keys;

    state_e        state_d, state_q;
    logic [2:0]    cursor_d, cursor_q;
    logic [2:0]    unlocked_d, unlocked_q;
    logic [2:0]    level_d, level_q;
    logic [TW-1:0] timer_d, timer_q;
    logic [2:0]    unlock_next;
    logic [6:0]    therm;

    logic [2:0]  select_d, select_q;
    logic        flag_cover_d, flag_cover_q;
    logic        level_load_d, level_load_q;
    logic        player_en_d, player_en_q;
    logic [1:0]  banner_d, banner_q;
    logic [15:0] led_d, led_q;

    key_edge #(.W(KEY_BITS)) u_key_edge (
        .clk      (clk),
        .rst      (rst),
        .key_down (key_down),
        .press    (press)
    );

    // Decode press events into the four menu actions
    always_comb begin
        go          = press[KEY_ENTER];
        back        = press[KEY_S] | press[KEY_DOWN];
        nxt         = press[KEY_D] | press[KEY_RIGHT];
        prv         = press[KEY_A] | press[KEY_LEFT];
        unused_keys = ^{press[KEY_W], press[KEY_UP], press[KEY_OTHER]};
    end

    // Next-state, timer, unlock and registered-output computation
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        unlocked_d  = unlocked_q;
        level_d     = level_q;
        timer_d     = '0;
        unlock_next = (level_q < LVL_MAX) ? level_q + 3'd1 : LVL_MAX;

        case (state_q)
            ST_MENU: begin
                if (go) begin
                    level_d = cursor_q;
                    state_d = ST_LOAD;
                end else if (!back) begin
                    if (nxt && !prv && cursor_q < unlocked_q)     cursor_d = cursor_q + 3'd1;
                    else if (prv && !nxt && cursor_q > 3'd1)      cursor_d = cursor_q - 3'd1;
                end
            end
            ST_LOAD: begin
                if (timer_q == LOAD_LAST) state_d = ST_PLAY;
                else                      timer_d = timer_q + TW'(1);
            end
            ST_PLAY: begin
                if (p1_dead || p2_dead) begin
                    state_d = ST_OVER;
                end else if (p1_goal && p2_goal) begin
                    state_d = ST_CLEAR;
                    if (unlock_next > unlocked_q) unlocked_d = unlock_next;
                end
`ifdef GAME_PAUSE_EN
                else if (go) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
            ST_CLEAR: begin
                if (go || timer_q == BANNER_LAST) begin
                    if (level_q < LVL_MAX) begin
                        level_d  = level_q + 3'd1;
                        cursor_d = level_q + 3'd1;
                        state_d  = ST_LOAD;
                    end else begin
                        cursor_d = 3'd1;
                        state_d  = ST_MENU;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_OVER: begin
                if (go) begin
                    state_d = ST_LOAD;
                end else if (back) begin
                    cursor_d = level_q;
                    state_d  = ST_MENU;
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSE: begin
                if (go)        state_d = ST_PLAY;
                else if (back) state_d = ST_MENU;
            end
`endif
            default: state_d = ST_MENU;
        endcase

        // Outputs are derived from the next state so they register together with it
        therm        = unlock_therm(unlocked_d);
        select_d     = (state_d == ST_MENU) ? 3'd0 : level_d;
        flag_cover_d = !(state_d == ST_LOAD || state_d == ST_PLAY);
        player_en_d  = (state_d == ST_PLAY);
        level_load_d = (state_d == ST_LOAD) && (state_q != ST_LOAD);
        if (state_d == ST_CLEAR)     banner_d = BANNER_CLEAR;
        else if (state_d == ST_OVER) banner_d = BANNER_OVER;
        else                         banner_d = BANNER_NONE;
        led_d                   = '0;
        led_d[NUM_LEVELS-1:0]   = therm[NUM_LEVELS-1:0];
        led_d[10:8]             = state_d;
        led_d[15:13]            = cursor_d;
    end

    // State, bookkeeping and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_MENU;
            cursor_q     <= 3'd1;
            unlocked_q   <= 3'd1;
            level_q      <= 3'd1;
            timer_q      <= '0;
            select_q     <= 3'd0;
            flag_cover_q <= 1'b1;
            level_load_q <= 1'b0;
            player_en_q  <= 1'b0;
            banner_q     <= BANNER_NONE;
            led_q        <= {3'd1, 12'd0, 1'b1};
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            unlocked_q   <= unlocked_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            select_q     <= select_d;
            flag_cover_q <= flag_cover_d;
            level_load_q <= level_load_d;
            player_en_q  <= player_en_d;
            banner_q     <= banner_d;
            led_q        <= led_d;
        end
    end

    assign select     = select_q;
    assign flag_cover = flag_cover_q;
    assign level_load = level_load_q;
    assign player_en  = player_en_q;
    assign banner     = banner_q;
    assign led        = led_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with a mode-level reference model.
module tb_game_flow_ctrl;

    localparam int NL  = 5;
    localparam int LC  = 16;
    localparam int BC  = 8;

    localparam logic [9:0] K_A     = 10'h002;
    localparam logic [9:0] K_S     = 10'h004;
    localparam logic [9:0] K_D     = 10'h008;
    localparam logic [9:0] K_LEFT  = 10'h020;
    localparam logic [9:0] K_DOWN  = 10'h040;
    localparam logic [9:0] K_RIGHT = 10'h080;
    localparam logic [9:0] K_ENTER = 10'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  key_down = '0;
    logic        p1_goal = 1'b0, p2_goal = 1'b0, p1_dead = 1'b0, p2_dead = 1'b0;
    logic [2:0]  select;
    logic        flag_cover, level_load, player_en;
    logic [1:0]  banner;
    logic [15:0] led;

    int n_checks = 0;
    int n_errors = 0;

    game_flow_ctrl #(
        .NUM_LEVELS    (NL),
        .LOAD_CYCLES   (LC),
        .BANNER_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_down   (key_down),
        .p1_goal    (p1_goal),
        .p2_goal    (p2_goal),
        .p1_dead    (p1_dead),
        .p2_dead    (p2_dead),
        .select     (select),
        .flag_cover (flag_cover),
        .level_load (level_load),
        .player_en  (player_en),
        .banner     (banner),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 menu, 1 load, 2 play, 3 clear, 4 over, 5 pause
    int         m_mode, m_cur, m_unl, m_lvl, m_cnt;
    bit         m_pulse;
    logic [9:0] m_prev;

    task automatic model_reset();
        m_mode = 0; m_cur = 1; m_unl = 1; m_lvl = 1; m_cnt = 0;
        m_pulse = 0; m_prev = '0;
    endtask

    task automatic model_step();
        logic [9:0] ev;
        bit go, back, nx, pv;
        int old;
        ev   = key_down & ~m_prev;
        go   = ev[8];
        back = ev[2] | ev[6];
        nx   = ev[3] | ev[7];
        pv   = ev[1] | ev[5];
        old  = m_mode;
        m_prev = key_down;
        m_cnt++;
        case (m_mode)
            0: if (go) begin
                   m_lvl = m_cur; m_mode = 1;
               end else if (!back && nx != pv) begin
                   if (nx && m_cur < m_unl) m_cur++;
                   if (pv && m_cur > 1)     m_cur--;
               end
            1: if (m_cnt == LC) m_mode = 2;
            2: if (p1_dead || p2_dead) m_mode = 4;
               else if (p1_goal && p2_goal) begin
                   m_mode = 3;
                   if (m_lvl + 1 <= NL && m_lvl + 1 > m_unl) m_unl = m_lvl + 1;
               end
`ifdef GAME_PAUSE_EN
               else if (go) m_mode = 5;
`endif
            3: if (go || m_cnt == BC) begin
                   if (m_lvl < NL) begin m_lvl++; m_cur = m_lvl; m_mode = 1; end
                   else begin m_cur = 1; m_mode = 0; end
               end
            4: if (go) m_mode = 1;
               else if (back) begin m_cur = m_lvl; m_mode = 0; end
            5: if (go) m_mode = 2;
               else if (back) m_mode = 0;
            default: m_mode = 0;
        endcase
        if (m_mode != old) m_cnt = 0;
        m_pulse = (m_mode == 1) && (old != 1);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        int e_sel, e_ban;
        bit e_flag, e_pe;
        logic [15:0] e_led;
        forever begin
            @(negedge clk);
            e_sel  = (m_mode == 0) ? 0 : m_lvl;
            e_flag = !(m_mode == 1 || m_mode == 2);
            e_pe   = (m_mode == 2);
            e_ban  = (m_mode == 3) ? 1 : (m_mode == 4) ? 2 : 0;
            e_led  = 16'((1 << m_unl) - 1) | 16'(m_mode << 8) | 16'(m_cur << 13);
            n_checks++;
            if (int'(select) != e_sel || flag_cover != e_flag || player_en != e_pe ||
                level_load != m_pulse || int'(banner) != e_ban || led != e_led) begin
                n_errors++;
                $display("FAIL model t=%0t: sel=%0d/%0d cover=%0b/%0b pe=%0b/%0b load=%0b/%0b banner=%0d/%0d led=%h/%h (actual/required)",
                         $time, select, e_sel, flag_cover, e_flag, player_en, e_pe,
                         level_load, m_pulse, banner, e_ban, led, e_led);
            end
        end
    end

    int  pulses = 0;
    bit  count_en = 0;
    initial forever begin
        @(negedge clk);
        if (count_en && level_load) pulses++;
    end

    task automatic chk(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tap(input logic [9:0] k);
        @(posedge clk); #1 key_down = k;
        @(posedge clk); #1 key_down = '0;
    endtask

    task automatic goals_once();
        p1_goal = 1; p2_goal = 1;
        tick(1);
        p1_goal = 0; p2_goal = 0;
    endtask

    task automatic die_once();
        p1_dead = 1;
        tick(1);
        p1_dead = 0;
    endtask

    initial begin
        #12;
        chk("rst_select", int'(select), 0);
        chk("rst_cover", int'(flag_cover), 1);
        chk("rst_load", int'(level_load), 0);
        chk("rst_pe", int'(player_en), 0);
        chk("rst_banner", int'(banner), 0);
        chk("rst_led", int'(led), 16'h2001);
        #11 rst = 1;

        // Cursor saturates at unlocked=1
        repeat (3) tap(K_D);
        chk("menu_sat_led", int'(led), 16'h2001);

        tap(K_ENTER);
        chk("load_pulse", int'(level_load), 1);
        chk("load_select", int'(select), 1);
        chk("load_led", int'(led), 16'h2101);
        tick(15);
        chk("load_pe_low", int'(player_en), 0);
        tick(1);
        chk("play_pe", int'(player_en), 1);

        // One player at goal is not enough
        p1_goal = 1;
        tick(3);
        chk("one_goal_state", int'(led[10:8]), 2);
        p2_goal = 1;
        tick(1);
        p1_goal = 0; p2_goal = 0;
        chk("clear_banner", int'(banner), 1);
        chk("clear_unlock", int'(led[4:0]), 5'b00011);
        tick(7);
        chk("clear_hold", int'(banner), 1);
        tick(1);
        chk("clear_to_load", int'(level_load), 1);
        chk("clear_sel2", int'(select), 2);

        // Death beats same-cycle goals
        tick(16);
        p2_dead = 1; p1_goal = 1; p2_goal = 1;
        tick(1);
        p2_dead = 0; p1_goal = 0; p2_goal = 0;
        chk("over_banner", int'(banner), 2);
        chk("over_unlock", int'(led[4:0]), 5'b00011);
        tap(K_ENTER);
        chk("retry_load", int'(level_load), 1);
        chk("retry_sel", int'(select), 2);

        // GO wins over BACK
        tick(16);
        die_once();
        tap(K_S | K_ENTER);
        chk("go_over_back", int'(level_load), 1);

        tick(16);
        die_once();
        tap(K_DOWN);
        chk("back_sel", int'(select), 0);
        chk("back_cursor", int'(led[15:13]), 2);

        // Clear levels 2..5, skipping the level-3 banner with GO
        tap(K_ENTER);
        for (int lv = 2; lv <= NL; lv++) begin
            tick(16);
            goals_once();
            if (lv == 3) tap(K_ENTER);
            else         tick(8);
        end
        chk("final_menu_led", int'(led), 16'h201F);
        chk("final_sel", int'(select), 0);

        // Menu navigation with cancel and BACK priority
        tap(K_RIGHT); tap(K_RIGHT);
        chk("nav_cur3", int'(led[15:13]), 3);
        tap(K_D | K_A);
        chk("nav_cancel", int'(led[15:13]), 3);
        tap(K_A);
        chk("nav_cur2", int'(led[15:13]), 2);
        tap(K_S | K_D);
        chk("nav_back_blocks", int'(led[15:13]), 2);
        repeat (3) tap(K_LEFT);
        chk("nav_floor", int'(led[15:13]), 1);

        // Held ENTER produces a single load
        count_en = 1;
        key_down = K_ENTER;
        tick(1000);
        key_down = '0;
        count_en = 0;
        chk("hold_one_load", pulses, 1);

        // Reset in the middle of the level_load pulse
        die_once();
        tap(K_ENTER);
        #2 rst = 0;
        #1;
        chk("rst_mid_load", int'(level_load), 0);
        chk("rst_mid_sel", int'(select), 0);
        chk("rst_mid_led", int'(led), 16'h2001);
        #2 rst = 1;

`ifdef GAME_PAUSE_EN
        tap(K_ENTER);
        tick(16);
        tap(K_ENTER);
        chk("pause_pe", int'(player_en), 0);
        chk("pause_state", int'(led[10:8]), 5);
        p1_dead = 1;
        tick(3);
        p1_dead = 0;
        chk("pause_ignore_dead", int'(led[10:8]), 5);
        tap(K_ENTER);
        chk("resume_no_load", int'(level_load), 0);
        chk("resume_pe", int'(player_en), 1);
`endif

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
